// File: rtl/memwb_pkg.sv
// Shared types and default sizing for the MEM/WB stage.
// Optional forwarding outputs are enabled in memwb_stage by defining MEMWB_FWD_EN.
package memwb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } memwb_state_t;

  localparam int DATA_W_DEF         = 32;
  localparam int REG_W_DEF          = 5;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int TIMEOUT_CNT_W      = 16;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for a data-memory access; expired flags the cycle whose
// missing ack would make the count reach LIMIT.
module mem_timeout_cnt #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Looking one step ahead lets the abort land on the same edge the count hits LIMIT.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage: issues data-memory accesses, stalls while waiting,
// and produces register-file writeback. Define MEMWB_FWD_EN for forwarding outputs.
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REG_W          = REG_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEMvalid,
  input  logic [DATA_W-1:0] MEMaluOut,
  input  logic [DATA_W-1:0] MEMwritedata,
  input  logic [REG_W-1:0]  MEMwriteReg,
  input  logic              MEMregWrite,
  input  logic              MEMmemtoReg,
  input  logic              MEMmemWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              WBregWrite,
  output logic [REG_W-1:0]  WBwriteReg,
  output logic [DATA_W-1:0] WBwriteData,
  output logic              memErr
`ifdef MEMWB_FWD_EN
  ,
  output logic              FWDvalid,
  output logic [REG_W-1:0]  FWDreg,
  output logic [DATA_W-1:0] FWDdata
`endif
);

  memwb_state_t      state;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [REG_W-1:0]  lat_reg;
  logic              lat_we;
  logic              lat_load;
  logic              lat_regwrite;

  logic mem_op;
  logic alu_op;
  logic aligned;
  logic in_idle;
  logic in_access;
  logic expired;

  assign mem_op    = MEMvalid && (MEMmemtoReg || MEMmemWrite);
  assign alu_op    = MEMvalid && !MEMmemtoReg && !MEMmemWrite;
  assign aligned   = is_aligned(MEMaluOut[1:0]);
  assign in_idle   = (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);

  mem_timeout_cnt #(
    .CNT_W (TIMEOUT_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (in_idle),
    .enable  (in_access && !dmem_ack),
    .expired (expired)
  );

  assign dmem_req   = in_access;
  assign dmem_we    = in_access && lat_we;
  assign dmem_addr  = lat_addr;
  assign dmem_wdata = lat_wdata;

  // Gated by rst_n so the stage never holds the pipeline while in reset.
  assign stall = rst_n &&
                 ((in_idle && mem_op && aligned) || (in_access && !dmem_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_reg      <= '0;
      lat_we       <= 1'b0;
      lat_load     <= 1'b0;
      lat_regwrite <= 1'b0;
      WBregWrite   <= 1'b0;
      WBwriteReg   <= '0;
      WBwriteData  <= '0;
      memErr       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_op && aligned) begin
            state        <= ST_ACCESS;
            lat_addr     <= MEMaluOut;
            lat_wdata    <= MEMwritedata;
            lat_reg      <= MEMwriteReg;
            lat_we       <= MEMmemWrite;
            lat_load     <= MEMmemtoReg && !MEMmemWrite;
            lat_regwrite <= MEMregWrite;
            WBregWrite   <= 1'b0;
          end else if (mem_op) begin
            WBregWrite <= 1'b0;
            memErr     <= 1'b1;
          end else if (alu_op) begin
            WBwriteData <= MEMaluOut;
            WBwriteReg  <= MEMwriteReg;
            WBregWrite  <= MEMregWrite && (MEMwriteReg != '0);
          end else begin
            WBregWrite <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            state <= ST_IDLE;
            if (lat_load) begin
              WBwriteData <= dmem_rdata;
              WBwriteReg  <= lat_reg;
              WBregWrite  <= lat_regwrite && (lat_reg != '0);
            end else begin
              WBregWrite <= 1'b0;
            end
          end else if (expired) begin
            state      <= ST_IDLE;
            WBregWrite <= 1'b0;
            memErr     <= 1'b1;
          end else begin
            WBregWrite <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          WBregWrite <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEMWB_FWD_EN
  // An ALU result still in the MEM slot is newer than the registered writeback.
  always_comb begin
    FWDvalid = WBregWrite;
    FWDreg   = WBwriteReg;
    FWDdata  = WBwriteData;
    if (in_idle && alu_op) begin
      FWDvalid = MEMregWrite && (MEMwriteReg != '0);
      FWDreg   = MEMwriteReg;
      FWDdata  = MEMaluOut;
    end
  end
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage built with TIMEOUT_CYCLES=4.
module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEMvalid;
  logic [31:0] MEMaluOut;
  logic [31:0] MEMwritedata;
  logic [4:0]  MEMwriteReg;
  logic        MEMregWrite, MEMmemtoReg, MEMmemWrite;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, WBregWrite, memErr;
  logic [4:0]  WBwriteReg;
  logic [31:0] WBwriteData;

  int checks = 0;
  int fails  = 0;

  int          stall_cnt, req_cnt;
  logic        we_seen;
  logic [31:0] addr_seen, wdata_seen;
  logic        addr_stable;

  always #5 clk = ~clk;

  memwb_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEMvalid(MEMvalid), .MEMaluOut(MEMaluOut), .MEMwritedata(MEMwritedata),
    .MEMwriteReg(MEMwriteReg), .MEMregWrite(MEMregWrite),
    .MEMmemtoReg(MEMmemtoReg), .MEMmemWrite(MEMmemWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .WBregWrite(WBregWrite), .WBwriteReg(WBwriteReg),
    .WBwriteData(WBwriteData), .memErr(memErr)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MEMvalid = 0; MEMaluOut = 0; MEMwritedata = 0; MEMwriteReg = 0;
    MEMregWrite = 0; MEMmemtoReg = 0; MEMmemWrite = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Drives one memory op and records what the memory side saw; ack_at=0 never acks.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic store,
                            input int ack_at, input logic [31:0] rdata);
    stall_cnt = 0; req_cnt = 0; we_seen = 0; addr_stable = 1;
    addr_seen = 0; wdata_seen = 0;
    MEMvalid = 1; MEMaluOut = addr; MEMwritedata = wdata; MEMwriteReg = rd;
    MEMregWrite = !store; MEMmemtoReg = !store; MEMmemWrite = store;
    #1;
    stall_cnt += int'(stall);
    req_cnt   += int'(dmem_req);
    next_cycle();
    MEMvalid = 0; MEMaluOut = 32'hFFFF_FFF0; MEMwritedata = 32'h1111_2222;
    for (int c = 1; c <= 12; c++) begin
      dmem_ack = (c == ack_at);
      dmem_rdata = rdata;
      #1;
      stall_cnt += int'(stall);
      req_cnt   += int'(dmem_req);
      if (c == 1) begin
        addr_seen = dmem_addr; wdata_seen = dmem_wdata; we_seen = dmem_we;
      end else if (dmem_req && (dmem_addr !== addr_seen || dmem_wdata !== wdata_seen)) begin
        addr_stable = 0;
      end
      @(posedge clk);
      #1;
      dmem_ack = 0;
      if (!dmem_req) break;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if ({dmem_we, dmem_addr, dmem_wdata} !== 65'd0) begin fails++; $display("FAIL reset_dmem got=%b/%h/%h exp=0", dmem_we, dmem_addr, dmem_wdata); end
    checks++; if ({WBregWrite, WBwriteReg, WBwriteData, memErr} !== 39'd0) begin fails++; $display("FAIL reset_wb got=%b/%0d/%h/%b exp=0", WBregWrite, WBwriteReg, WBwriteData, memErr); end
    @(negedge clk);
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_alu();
    logic stall_seen;
    MEMvalid = 1; MEMaluOut = 32'h0000_1234; MEMwriteReg = 7; MEMregWrite = 1;
    #1;
    stall_seen = stall;
    next_cycle();
    stall_seen |= stall;
    checks++; if ({WBregWrite, WBwriteReg, WBwriteData} !== {1'b1, 5'd7, 32'h1234}) begin fails++; $display("FAIL alu_wb got=%b/%0d/%h exp=1/7/00001234", WBregWrite, WBwriteReg, WBwriteData); end
    checks++; if (stall_seen !== 1'b0) begin fails++; $display("FAIL alu_stall got=%b exp=0", stall_seen); end
    idle_inputs();
    next_cycle();
    checks++; if ({WBregWrite, WBwriteReg, WBwriteData} !== {1'b0, 5'd7, 32'h1234}) begin fails++; $display("FAIL bubble_hold got=%b/%0d/%h exp=0/7/00001234", WBregWrite, WBwriteReg, WBwriteData); end
  endtask

  task automatic test_load();
    run_access(32'h100, 32'h0, 5'd9, 1'b0, 4, 32'hDEAD_BEEF);
    checks++; if (stall_cnt !== 4) begin fails++; $display("FAIL load_stall_cycles got=%0d exp=4", stall_cnt); end
    checks++; if (req_cnt !== 4) begin fails++; $display("FAIL load_req_cycles got=%0d exp=4", req_cnt); end
    checks++; if ({addr_seen, we_seen, addr_stable} !== {32'h100, 1'b0, 1'b1}) begin fails++; $display("FAIL load_dmem got=%h/%b/%b exp=00000100/0/1", addr_seen, we_seen, addr_stable); end
    checks++; if ({WBregWrite, WBwriteReg, WBwriteData} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin fails++; $display("FAIL load_wb got=%b/%0d/%h exp=1/9/deadbeef", WBregWrite, WBwriteReg, WBwriteData); end
  endtask

  task automatic test_store();
    run_access(32'h204, 32'hA5A5_A5A5, 5'd4, 1'b1, 1, 32'h0);
    checks++; if ({we_seen, addr_seen, wdata_seen} !== {1'b1, 32'h204, 32'hA5A5_A5A5}) begin fails++; $display("FAIL store_dmem got=%b/%h/%h exp=1/00000204/a5a5a5a5", we_seen, addr_seen, wdata_seen); end
    checks++; if (stall_cnt !== 1) begin fails++; $display("FAIL store_stall_cycles got=%0d exp=1", stall_cnt); end
    checks++; if ({WBregWrite, WBwriteData} !== {1'b0, 32'hDEAD_BEEF}) begin fails++; $display("FAIL store_wb got=%b/%h exp=0/deadbeef", WBregWrite, WBwriteData); end
  endtask

  task automatic test_ack_at_limit();
    run_access(32'h300, 32'h0, 5'd3, 1'b0, 4, 32'h1234_5678);
    checks++; if (req_cnt !== 4) begin fails++; $display("FAIL limit_req_cycles got=%0d exp=4", req_cnt); end
    checks++; if ({WBregWrite, WBwriteReg, WBwriteData, memErr} !== {1'b1, 5'd3, 32'h1234_5678, 1'b0}) begin fails++; $display("FAIL limit_wb got=%b/%0d/%h/%b exp=1/3/12345678/0", WBregWrite, WBwriteReg, WBwriteData, memErr); end
  endtask

  task automatic test_misaligned();
    MEMvalid = 1; MEMaluOut = 32'h102; MEMwriteReg = 6; MEMregWrite = 1; MEMmemtoReg = 1;
    #1;
    checks++; if ({stall, dmem_req} !== 2'b00) begin fails++; $display("FAIL misalign_comb got=%b/%b exp=0/0", stall, dmem_req); end
    next_cycle();
    checks++; if ({dmem_req, WBregWrite, memErr} !== 3'b001) begin fails++; $display("FAIL misalign_err got=%b/%b/%b exp=0/0/1", dmem_req, WBregWrite, memErr); end
    MEMmemtoReg = 0; MEMaluOut = 32'h55; MEMwriteReg = 0; MEMregWrite = 1;
    next_cycle();
    checks++; if ({WBregWrite, WBwriteData} !== {1'b0, 32'h55}) begin fails++; $display("FAIL alu_reg0 got=%b/%h exp=0/00000055", WBregWrite, WBwriteData); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_timeout();
    rst_n = 0;
    #2;
    rst_n = 1;
    next_cycle();
    checks++; if (memErr !== 1'b0) begin fails++; $display("FAIL timeout_pre_err got=%b exp=0", memErr); end
    run_access(32'h500, 32'h0, 5'd2, 1'b0, 0, 32'h0);
    checks++; if ({req_cnt, stall_cnt} !== {32'd4, 32'd5}) begin fails++; $display("FAIL timeout_cycles got=%0d/%0d exp=4/5", req_cnt, stall_cnt); end
    checks++; if ({dmem_req, stall, WBregWrite, memErr} !== 4'b0001) begin fails++; $display("FAIL timeout_abort got=%b/%b/%b/%b exp=0/0/0/1", dmem_req, stall, WBregWrite, memErr); end
    next_cycle();
    checks++; if (memErr !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", memErr); end
  endtask

  task automatic test_reset_mid_access();
    MEMvalid = 1; MEMaluOut = 32'h400; MEMwriteReg = 5; MEMregWrite = 1; MEMmemtoReg = 1;
    next_cycle();
    idle_inputs();
    checks++; if ({dmem_req, stall} !== 2'b11) begin fails++; $display("FAIL midrst_pre got=%b/%b exp=1/1", dmem_req, stall); end
    #1;
    rst_n = 0;
    #1;
    checks++; if ({dmem_req, stall, memErr} !== 3'b000) begin fails++; $display("FAIL midrst_async got=%b/%b/%b exp=0/0/0", dmem_req, stall, memErr); end
    #2;
    rst_n = 1;
    next_cycle();
    dmem_ack = 1; dmem_rdata = 32'h0BAD_0BAD;
    next_cycle();
    dmem_ack = 0;
    checks++; if ({WBregWrite, WBwriteData, dmem_req, stall} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin fails++; $display("FAIL stray_ack got=%b/%h/%b/%b exp=0/00000000/0/0", WBregWrite, WBwriteData, dmem_req, stall); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_at_limit();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
